reorder_buffer: RTL and testbench

- Circular reorder buffer at the receiving end of the decoder's ROB interface.
- Allocates an 8-bit tag per issued instruction (tag 0 = "value in register file").
- Answers the decoder's two operand look-ups and captures function-unit results from the CDB.
- Commits in program order to the register file and store unit, and raises a pipeline flush when a mispredicted control instruction commits.

---
 rtl/rob_pkg.sv | 33 +++
 rtl/rob_lookup.sv | 42 ++++
 rtl/reorder_buffer.sv | 195 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rob_pkg;

    localparam int ROB_BUS_W = 44;
    localparam int TAG_W     = 8;
    localparam int DATA_W    = 32;

    // Issue bus layout: {opcode, pc_or_imm, rd}
    localparam int OPC_LSB = 37;
    localparam int OPC_W   = 7;
    localparam int PC_LSB  = 5;
    localparam int PC_W    = 32;
    localparam int RD_LSB  = 0;
    localparam int RD_W    = 5;

    localparam logic [OPC_W-1:0] INST_TYPE_R_M  = 7'b0110011;
    localparam logic [OPC_W-1:0] INST_TYPE_I_M  = 7'b0010011;
    localparam logic [OPC_W-1:0] INST_TYPE_I_L  = 7'b0000011;
    localparam logic [OPC_W-1:0] INST_TYPE_I_J  = 7'b1100111;
    localparam logic [OPC_W-1:0] INST_TYPE_S    = 7'b0100011;
    localparam logic [OPC_W-1:0] INST_TYPE_B    = 7'b1100011;
    localparam logic [OPC_W-1:0] INST_TYPE_AUIPC = 7'b0010111;
    localparam logic [OPC_W-1:0] INST_TYPE_LUI  = 7'b0110111;
    localparam logic [OPC_W-1:0] INST_TYPE_J    = 7'b1101111;

    // Stores and branches have no destination register.
    function automatic logic writes_rd(input logic [OPC_W-1:0] opcode);
        return !((opcode == INST_TYPE_S) || (opcode == INST_TYPE_B));
    endfunction

endpackage

// File: rtl/rob_lookup.sv
// Operand look-up port: maps a tag to a ready value, with same-cycle CDB bypass.
// Latency: purely combinational.
// Backpressure: none; enable=0 tells the decoder to wait on the tag instead.
module rob_lookup
    import rob_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic                         check,
    input  logic [TAG_W-1:0]             tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_value,
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [DEPTH-1:0]             entry_ready,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_value,
    output logic                         value_enable,
    output logic [DATA_W-1:0]            value
);

    logic             in_range;
    logic [IDX_W-1:0] idx;

    // Bypass wins over the stored copy so a result is usable the cycle it is broadcast.
    always_comb begin
        value_enable = 1'b0;
        value        = '0;
        in_range     = (tag != '0) && (tag <= TAG_W'(DEPTH));
        idx          = IDX_W'(tag - TAG_W'(1));
        if (check) begin
            if (cdb_valid && (cdb_tag == tag) && (tag != '0)) begin
                value_enable = 1'b1;
                value        = cdb_value;
            end else if (in_range && entry_valid[idx] && entry_ready[idx]) begin
                value_enable = 1'b1;
                value        = entry_value[idx];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture, in-order commit and mispredict flush.
// Latency: CDB write at edge N commits at edge N+1 earliest; commit/flush outputs are registered pulses.
// Backpressure: rob_full stalls the decoder; writes while full (judged on registered count) are dropped.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = 4,
    parameter int ROB_BUS = ROB_BUS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rob_write,
    input  logic [ROB_BUS-1:0] rob_bus,
    output logic [TAG_W-1:0]   rob_tag,
    output logic               rob_full,
    input  logic               rob_check_rs1,
    input  logic               rob_check_rs2,
    input  logic [TAG_W-1:0]   rob_tag1,
    input  logic [TAG_W-1:0]   rob_tag2,
    output logic               rob_value1_enable,
    output logic               rob_value2_enable,
    output logic [DATA_W-1:0]  rob_rs1,
    output logic [DATA_W-1:0]  rob_rs2,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_value,
    input  logic               cdb_mispredict,
    input  logic [DATA_W-1:0]  cdb_target,
    output logic               commit_valid,
    output logic               commit_reg_we,
    output logic [RD_W-1:0]    commit_rd,
    output logic [TAG_W-1:0]   commit_tag,
    output logic [DATA_W-1:0]  commit_value,
    output logic               commit_store,
    output logic               flush_o,
    output logic [DATA_W-1:0]  flush_pc
);

    logic [DEPTH-1:0]             valid_q, valid_d, ready_q, ready_d, mispredict_q, mispredict_d;
    logic [DEPTH-1:0][OPC_W-1:0]  opcode_q, opcode_d;
    logic [DEPTH-1:0][RD_W-1:0]   rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0] value_q, value_d, target_q, target_d;
    logic [IDX_W-1:0]             head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]               count_q, count_d;

    logic               commit_valid_q, commit_valid_d, commit_reg_we_q, commit_reg_we_d;
    logic               commit_store_q, commit_store_d, flush_q, flush_d;
    logic [RD_W-1:0]    commit_rd_q, commit_rd_d;
    logic [TAG_W-1:0]   commit_tag_q, commit_tag_d;
    logic [DATA_W-1:0]  commit_value_q, commit_value_d, flush_pc_q, flush_pc_d;

    logic               alloc, commit_fire, wb_hit;
    logic [IDX_W-1:0]   wb_idx;

    // Retire needs only opcode and rd; branch targets arrive on the CDB, so pc_or_imm is not kept.
    logic [PC_W-1:0]    unused_pc_or_imm;
    assign unused_pc_or_imm = rob_bus[PC_LSB +: PC_W];

    assign rob_full    = (count_q == (IDX_W+1)'(DEPTH));
    assign rob_tag     = rob_full ? '0 : TAG_W'(tail_q) + TAG_W'(1);
    assign alloc       = rob_write && !rob_full;
    assign commit_fire = valid_q[head_q] && ready_q[head_q];
    assign wb_idx      = IDX_W'(cdb_tag - TAG_W'(1));
    assign wb_hit      = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_W'(DEPTH)) && valid_q[wb_idx];

    rob_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lookup1 (
        .check(rob_check_rs1), .tag(rob_tag1),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .entry_valid(valid_q), .entry_ready(ready_q), .entry_value(value_q),
        .value_enable(rob_value1_enable), .value(rob_rs1)
    );

    rob_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lookup2 (
        .check(rob_check_rs2), .tag(rob_tag2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .entry_valid(valid_q), .entry_ready(ready_q), .entry_value(value_q),
        .value_enable(rob_value2_enable), .value(rob_rs2)
    );

    // Next state: writeback, then commit clears head, then allocate at tail; a flush overrides all.
    always_comb begin
        valid_d        = valid_q;
        ready_d        = ready_q;
        mispredict_d   = mispredict_q;
        opcode_d       = opcode_q;
        rd_d           = rd_q;
        value_d        = value_q;
        target_d       = target_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q + {{IDX_W{1'b0}}, alloc} - {{IDX_W{1'b0}}, commit_fire};
        commit_valid_d = 1'b0;
        commit_reg_we_d = 1'b0;
        commit_store_d = 1'b0;
        commit_rd_d    = '0;
        commit_tag_d   = '0;
        commit_value_d = '0;
        flush_d        = 1'b0;
        flush_pc_d     = '0;

        if (wb_hit) begin
            ready_d[wb_idx]      = 1'b1;
            value_d[wb_idx]      = cdb_value;
            mispredict_d[wb_idx] = cdb_mispredict;
            target_d[wb_idx]     = cdb_target;
        end

        if (commit_fire) begin
            commit_valid_d       = 1'b1;
            commit_tag_d         = TAG_W'(head_q) + TAG_W'(1);
            commit_rd_d          = rd_q[head_q];
            commit_value_d       = value_q[head_q];
            commit_reg_we_d      = writes_rd(opcode_q[head_q]) && (rd_q[head_q] != '0);
            commit_store_d       = (opcode_q[head_q] == INST_TYPE_S);
            valid_d[head_q]      = 1'b0;
            ready_d[head_q]      = 1'b0;
            mispredict_d[head_q] = 1'b0;
            head_d               = head_q + IDX_W'(1);
        end

        if (alloc) begin
            valid_d[tail_q]      = 1'b1;
            ready_d[tail_q]      = 1'b0;
            mispredict_d[tail_q] = 1'b0;
            opcode_d[tail_q]     = rob_bus[OPC_LSB +: OPC_W];
            rd_d[tail_q]         = rob_bus[RD_LSB +: RD_W];
            tail_d               = tail_q + IDX_W'(1);
        end

        if (commit_fire && mispredict_q[head_q]) begin
            flush_d      = 1'b1;
            flush_pc_d   = target_q[head_q];
            valid_d      = '0;
            ready_d      = '0;
            mispredict_d = '0;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
        end
    end

    // State and output registers; reset empties the buffer and silences every pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= '0;
            ready_q        <= '0;
            mispredict_q   <= '0;
            opcode_q       <= '0;
            rd_q           <= '0;
            value_q        <= '0;
            target_q       <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_reg_we_q <= 1'b0;
            commit_store_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_tag_q   <= '0;
            commit_value_q <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            mispredict_q   <= mispredict_d;
            opcode_q       <= opcode_d;
            rd_q           <= rd_d;
            value_q        <= value_d;
            target_q       <= target_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_reg_we_q <= commit_reg_we_d;
            commit_store_q <= commit_store_d;
            commit_rd_q    <= commit_rd_d;
            commit_tag_q   <= commit_tag_d;
            commit_value_q <= commit_value_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_reg_we = commit_reg_we_q;
    assign commit_store  = commit_store_q;
    assign commit_rd     = commit_rd_q;
    assign commit_tag    = commit_tag_q;
    assign commit_value  = commit_value_q;
    assign flush_o       = flush_q;
    assign flush_pc      = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: table of per-cycle vectors plus hand-written corner sequences.
// Latency: combinational outputs checked before the edge, registered outputs 1 time unit after it.
// Backpressure: full/wrap and write-while-committing-at-full cases exercised explicitly.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rob_write;
    logic [43:0]       rob_bus;
    logic [7:0]        rob_tag;
    logic              rob_full;
    logic              rob_check_rs1, rob_check_rs2;
    logic [7:0]        rob_tag1, rob_tag2;
    logic              rob_value1_enable, rob_value2_enable;
    logic [31:0]       rob_rs1, rob_rs2;
    logic              cdb_valid;
    logic [7:0]        cdb_tag;
    logic [31:0]       cdb_value;
    logic              cdb_mispredict;
    logic [31:0]       cdb_target;
    logic              commit_valid, commit_reg_we, commit_store;
    logic [4:0]        commit_rd;
    logic [7:0]        commit_tag;
    logic [31:0]       commit_value;
    logic              flush_o;
    logic [31:0]       flush_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(16), .IDX_W(4), .ROB_BUS(44)) dut (
        .clk(clk), .rst_n(rst_n),
        .rob_write(rob_write), .rob_bus(rob_bus), .rob_tag(rob_tag), .rob_full(rob_full),
        .rob_check_rs1(rob_check_rs1), .rob_check_rs2(rob_check_rs2),
        .rob_tag1(rob_tag1), .rob_tag2(rob_tag2),
        .rob_value1_enable(rob_value1_enable), .rob_value2_enable(rob_value2_enable),
        .rob_rs1(rob_rs1), .rob_rs2(rob_rs2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .commit_valid(commit_valid), .commit_reg_we(commit_reg_we), .commit_rd(commit_rd),
        .commit_tag(commit_tag), .commit_value(commit_value), .commit_store(commit_store),
        .flush_o(flush_o), .flush_pc(flush_pc)
    );

    typedef struct {
        logic        wr;   logic [6:0] op;   logic [4:0] rd;
        logic        cv;   logic [7:0] ct;   logic [31:0] cval;
        logic        c1;   logic [7:0] t1;   logic c2;  logic [7:0] t2;
        logic [7:0]  e_tag;
        logic        e_en1; logic [31:0] e_v1; logic e_en2; logic [31:0] e_v2;
        logic        e_cv;  logic [7:0] e_ctag; logic e_we; logic e_st; logic [31:0] e_cval;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rob_write = 1'b0; rob_bus = '0;
        rob_check_rs1 = 1'b0; rob_check_rs2 = 1'b0; rob_tag1 = '0; rob_tag2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target = '0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rd);
        rob_write = 1'b1;
        rob_bus   = {op, 32'h0000_1000, rd};
    endtask

    task automatic cdb(input logic [7:0] tag, input logic [31:0] val, input logic mp, input logic [31:0] tgt);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val; cdb_mispredict = mp; cdb_target = tgt;
    endtask

    task automatic edge_after();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_commit(input string nm, input logic cv, input logic [7:0] ct, input logic we,
                              input logic st, input logic [31:0] cval);
        chk({nm, ".commit_valid"}, 32'(commit_valid), 32'(cv));
        chk({nm, ".commit_tag"}, 32'(commit_tag), 32'(ct));
        chk({nm, ".commit_reg_we"}, 32'(commit_reg_we), 32'(we));
        chk({nm, ".commit_store"}, 32'(commit_store), 32'(st));
        chk({nm, ".commit_value"}, commit_value, cval);
    endtask

    initial begin
        // wr op rd | cdb v tag val | c1 t1 c2 t2 | e_tag | en1 v1 en2 v2 | cv ctag we st cval
        vecs[0]  = '{1, INST_TYPE_R_M, 1, 0, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 0,         0, 0, 0, 0, 0};
        vecs[1]  = '{1, INST_TYPE_S,   2, 0, 0, 0,          0, 0, 0, 0, 2, 0, 0, 0, 0,         0, 0, 0, 0, 0};
        vecs[2]  = '{1, INST_TYPE_B,   0, 0, 0, 0,          0, 0, 0, 0, 3, 0, 0, 0, 0,         0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0,             0, 0, 0, 0,          1, 3, 1, 1, 4, 0, 0, 0, 0,         0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0,             0, 1, 1, 32'h55,     1, 1, 0, 0, 4, 1, 32'h55, 0, 0,    0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0,             0, 1, 3, 32'hA5A5,   1, 3, 1, 1, 4, 1, 32'hA5A5, 1, 32'h55, 1, 1, 1, 0, 32'h55};
        vecs[6]  = '{0, 0,             0, 0, 0, 0,          1, 3, 1, 1, 4, 1, 32'hA5A5, 0, 0,  0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0,             0, 1, 2, 32'h77,     0, 0, 0, 0, 4, 0, 0, 0, 0,         0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0,             0, 0, 0, 0,          0, 0, 0, 0, 4, 0, 0, 0, 0,         1, 2, 0, 1, 32'h77};
        vecs[9]  = '{0, 0,             0, 0, 0, 0,          0, 0, 0, 0, 4, 0, 0, 0, 0,         1, 3, 0, 0, 32'hA5A5};
        vecs[10] = '{0, 0,             0, 0, 0, 0,          0, 0, 0, 0, 4, 0, 0, 0, 0,         0, 0, 0, 0, 0};

        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset.rob_tag", 32'(rob_tag), 32'd1);
        chk("reset.rob_full", 32'(rob_full), 32'd0);
        chk_commit("reset", 0, 0, 0, 0, 0);
        chk("reset.flush_o", 32'(flush_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: issue R/S/B, lookups, out-of-order completion, in-order commit.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle_inputs();
            if (vecs[i].wr) issue(vecs[i].op, vecs[i].rd);
            if (vecs[i].cv) cdb(vecs[i].ct, vecs[i].cval, 1'b0, 32'h0);
            rob_check_rs1 = vecs[i].c1; rob_tag1 = vecs[i].t1;
            rob_check_rs2 = vecs[i].c2; rob_tag2 = vecs[i].t2;
            #1;
            chk($sformatf("v%0d.rob_tag", i), 32'(rob_tag), 32'(vecs[i].e_tag));
            chk($sformatf("v%0d.rob_full", i), 32'(rob_full), 32'd0);
            chk($sformatf("v%0d.en1", i), 32'(rob_value1_enable), 32'(vecs[i].e_en1));
            chk($sformatf("v%0d.rs1", i), rob_rs1, vecs[i].e_v1);
            chk($sformatf("v%0d.en2", i), 32'(rob_value2_enable), 32'(vecs[i].e_en2));
            chk($sformatf("v%0d.rs2", i), rob_rs2, vecs[i].e_v2);
            edge_after();
            chk_commit($sformatf("v%0d", i), vecs[i].e_cv, vecs[i].e_ctag, vecs[i].e_we,
                       vecs[i].e_st, vecs[i].e_cval);
            chk($sformatf("v%0d.flush_o", i), 32'(flush_o), 32'd0);
        end

        // Full and wrap.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            issue(INST_TYPE_R_M, 5'd5);
            #1;
            chk($sformatf("fill%0d.rob_tag", i), 32'(rob_tag), 32'(i + 1));
            @(negedge clk);
        end
        idle_inputs();
        issue(INST_TYPE_R_M, 5'd6);               // 17th write, must be ignored
        #1;
        chk("full.rob_full", 32'(rob_full), 32'd1);
        chk("full.rob_tag", 32'(rob_tag), 32'd0);
        @(negedge clk);
        idle_inputs();
        cdb(8'd1, 32'h11, 1'b0, 32'h0);
        #1;
        chk("full17.rob_tag", 32'(rob_tag), 32'd0);
        @(negedge clk);
        idle_inputs();
        edge_after();
        chk_commit("wrap.c1", 1, 1, 1, 0, 32'h11);
        chk("wrap.rob_full", 32'(rob_full), 32'd0);
        chk("wrap.rob_tag", 32'(rob_tag), 32'd1);
        @(negedge clk);
        issue(INST_TYPE_R_M, 5'd7);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("wrap.refull", 32'(rob_full), 32'd1);
        chk("wrap.refull_tag", 32'(rob_tag), 32'd0);
        cdb(8'd2, 32'h22, 1'b0, 32'h0);
        @(negedge clk);
        idle_inputs();
        issue(INST_TYPE_R_M, 5'd8);               // commit this cycle, but count still registered full
        edge_after();
        chk_commit("wrap.c2", 1, 2, 1, 0, 32'h22);
        chk("wrap.write_refused_tag", 32'(rob_tag), 32'd2);

        // Mispredict flush.
        @(negedge clk);
        do_reset();
        issue(INST_TYPE_R_M, 5'd3); @(negedge clk);
        issue(INST_TYPE_I_J, 5'd1); @(negedge clk);
        for (int i = 0; i < 3; i++) begin issue(INST_TYPE_R_M, 5'd4); @(negedge clk); end
        idle_inputs();
        cdb(8'd1, 32'h10, 1'b0, 32'h0);
        @(negedge clk);
        idle_inputs();
        cdb(8'd2, 32'h44, 1'b1, 32'h100);
        edge_after();
        chk_commit("mp.c1", 1, 1, 1, 0, 32'h10);
        chk("mp.c1.flush_o", 32'(flush_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        issue(INST_TYPE_R_M, 5'd9);               // discarded by the flush
        cdb(8'd4, 32'h99, 1'b0, 32'h0);           // discarded by the flush
        edge_after();
        chk_commit("mp.c2", 1, 2, 1, 0, 32'h44);
        chk("mp.flush_o", 32'(flush_o), 32'd1);
        chk("mp.flush_pc", flush_pc, 32'h100);
        @(negedge clk);
        idle_inputs();
        cdb(8'd4, 32'h99, 1'b0, 32'h0);           // stale, entry invalid
        #1;
        chk("mp.after.rob_tag", 32'(rob_tag), 32'd1);
        edge_after();
        chk("mp.flush_pulse", 32'(flush_o), 32'd0);
        chk("mp.after.commit_valid", 32'(commit_valid), 32'd0);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 5; i++) begin issue(INST_TYPE_R_M, 5'd2); @(negedge clk); end
        idle_inputs();
        rob_check_rs1 = 1'b1; rob_tag1 = 8'd4;
        #1;
        chk("mp.stale_dropped.en1", 32'(rob_value1_enable), 32'd0);
        chk("mp.stale_dropped.rs1", rob_rs1, 32'd0);
        chk("mp.refill.rob_tag", 32'(rob_tag), 32'd6);

        // Async reset with five entries pending and a commit pulse on the outputs.
        @(negedge clk);
        idle_inputs();
        cdb(8'd1, 32'h21, 1'b0, 32'h0);
        @(negedge clk);
        idle_inputs();
        cdb(8'd2, 32'h31, 1'b0, 32'h0);
        edge_after();
        chk_commit("rst.pre", 1, 1, 1, 0, 32'h21);
        #1;
        rst_n = 1'b0;
        #1;
        chk_commit("rst.async", 0, 0, 0, 0, 0);
        chk("rst.async.rob_tag", 32'(rob_tag), 32'd1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_after();
            chk($sformatf("rst.post%0d.commit_valid", i), 32'(commit_valid), 32'd0);
        end
        chk("rst.post.rob_tag", 32'(rob_tag), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
